adc_stream_ctrl: RTL

Parametrised controller that turns FT245 command bytes into ADC capture runs and streams the captured sample RAM back to the host as framed packets. It sits between the FT245 byte-level interface and the ADC capture engine with its sample RAM. Compared with the previous controller it adds:
- configurable sample width, RAM depth and capture length;
- a continuous-capture mode with abort;
- a status-poll reply;
- a header/checksum frame around each capture.

---
 rtl/adc_stream_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/adc_stream_ctrl.sv
// rtl/adc_stream_ctrl.sv - FT245 command decoder, capture sequencer and framed sample streamer
// Frames are HDR_BYTE, N samples LSB-first, then an XOR checksum of the sample bytes.
module adc_stream_ctrl #(
  parameter int         SAMPLE_W    = 16,
  parameter int         ADDR_W      = 10,
  parameter int         DIV_W       = 11,
  parameter int         DIV_DEFAULT = 3,
  parameter logic [7:0] HDR_BYTE    = 8'hA5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                rx_done,
  input  logic [7:0]          rx_data,
  input  logic                tx_busy,
  input  logic                tx_done,
  output logic                tx_en,
  output logic [7:0]          tx_data,
  output logic                cap_start,
  input  logic                cap_done,
  output logic [DIV_W-1:0]    divider,
  output logic [ADDR_W-1:0]   cap_len_m1,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [SAMPLE_W-1:0] ram_data,
  output logic                busy,
  output logic                frame_done
);

  localparam int NB = (SAMPLE_W + 7) / 8;
  localparam int PW = NB * 8;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_WAIT_CAP, S_HDR, S_RD, S_LATCH, S_SEND, S_CHK, S_END
  } state_t;

  state_t          state, state_nxt;
  logic            cmd_vld;
  logic [3:0]      cmd_code, cmd_arg;
  logic [3:0]      len_exp;
  logic            cont, poll_pend, abort_pend;
  logic            outst, sent;
  logic [7:0]      chk;
  logic [PW-1:0]   sh;
  logic [3:0]      k;
  logic [ADDR_W:0] len_pow;

  logic cmd_start, cmd_cont, cmd_poll, cmd_div, cmd_len, cmd_abort;
  logic in_frame, abrt, can_tx, byte_done;
  logic [7:0] status;

  assign cmd_start = cmd_vld && (cmd_code == 4'h1);
  assign cmd_poll  = cmd_vld && (cmd_code == 4'h2);
  assign cmd_cont  = cmd_vld && (cmd_code == 4'h3);
  assign cmd_div   = cmd_vld && (cmd_code == 4'h4);
  assign cmd_len   = cmd_vld && (cmd_code == 4'h6);
  assign cmd_abort = cmd_vld && (cmd_code == 4'h8);

  assign busy      = (state != S_IDLE);
  assign in_frame  = state inside {S_HDR, S_RD, S_LATCH, S_SEND, S_CHK};
  assign abrt      = in_frame && (abort_pend || cmd_abort);
  assign can_tx    = !tx_busy && !outst;
  // sent marks the outstanding byte as belonging to the current frame state
  assign byte_done = sent && tx_done;
  assign status    = {busy, cont, 2'b00, len_exp};

  assign len_pow    = (ADDR_W+1)'(1) << len_exp;
  assign cap_len_m1 = (int'(len_exp) >= ADDR_W) ? '1 : ADDR_W'(len_pow - (ADDR_W+1)'(1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (cmd_start || cmd_cont) state_nxt = S_START;
      S_START:    state_nxt = S_WAIT_CAP;
      S_WAIT_CAP: begin
        if (cmd_abort)     state_nxt = S_IDLE;
        else if (cap_done) state_nxt = S_HDR;
      end
      S_HDR:      if (byte_done) state_nxt = S_RD;
      S_RD:       state_nxt = S_LATCH;
      S_LATCH:    state_nxt = S_SEND;
      S_SEND: begin
        if (byte_done) begin
          if (k < 4'(NB-1))              state_nxt = S_SEND;
          else if (ram_addr == cap_len_m1) state_nxt = S_CHK;
          else                           state_nxt = S_RD;
        end
      end
      S_CHK:      if (byte_done) state_nxt = S_END;
      S_END:      if (frame_done) state_nxt = cont ? S_START : S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    // abort lets the byte in flight finish, then skips straight to END
    if (abrt && (!outst || tx_done)) state_nxt = S_END;
  end

  always_comb begin
    tx_en      = 1'b0;
    tx_data    = 8'h00;
    cap_start  = 1'b0;
    frame_done = 1'b0;
    case (state)
      S_IDLE: if (poll_pend) begin
        tx_data = status;
        tx_en   = can_tx;
      end
      S_START: cap_start = 1'b1;
      S_HDR: begin
        tx_data = HDR_BYTE;
        tx_en   = can_tx && !abrt;
      end
      S_SEND: begin
        tx_data = sh[7:0];
        tx_en   = can_tx && !abrt;
      end
      S_CHK: begin
        tx_data = chk;
        tx_en   = can_tx && !abrt;
      end
      S_END: begin
        if (poll_pend) begin
          tx_data = status;
          tx_en   = can_tx;
        end else begin
          frame_done = !outst;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cmd_vld    <= 1'b0;
      cmd_code   <= 4'h0;
      cmd_arg    <= 4'h0;
      divider    <= DIV_W'(DIV_DEFAULT);
      len_exp    <= 4'(ADDR_W);
      cont       <= 1'b0;
      poll_pend  <= 1'b0;
      abort_pend <= 1'b0;
      outst      <= 1'b0;
      sent       <= 1'b0;
      chk        <= 8'h00;
      ram_addr   <= '0;
      sh         <= '0;
      k          <= 4'd0;
    end else begin
      cmd_vld <= rx_done;
      if (rx_done) begin
        cmd_code <= rx_data[3:0];
        cmd_arg  <= rx_data[7:4];
      end
      if (state == S_IDLE && cmd_div) divider <= DIV_W'(cmd_arg);
      if (state == S_IDLE && cmd_len) len_exp <= cmd_arg;
      if (cmd_abort)                       cont <= 1'b0;
      else if (state == S_IDLE && cmd_cont) cont <= 1'b1;
      if (cmd_poll)                                        poll_pend <= 1'b1;
      else if (tx_en && (state == S_IDLE || state == S_END)) poll_pend <= 1'b0;
      abort_pend <= abrt;
      if (tx_en)        outst <= 1'b1;
      else if (tx_done) outst <= 1'b0;
      if (tx_done)                sent <= 1'b0;
      else if (tx_en && in_frame) sent <= 1'b1;
      if (state == S_HDR)                chk <= 8'h00;
      else if (state == S_SEND && tx_en) chk <= chk ^ sh[7:0];
      if (state == S_HDR && state_nxt == S_RD)       ram_addr <= '0;
      else if (state == S_SEND && state_nxt == S_RD) ram_addr <= ram_addr + ADDR_W'(1);
      if (state == S_LATCH) begin
        sh <= PW'(ram_data);
        k  <= 4'd0;
      end else if (state == S_SEND && state_nxt == S_SEND && byte_done) begin
        sh <= sh >> 8;
        k  <= k + 4'd1;
      end
    end
  end

endmodule
